// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle MIPS datapath (PC, unified instruction/data
// memory, register file, ALU, muxes). One state per cycle; memory states
// stall on mem_ready and may give up after WAIT_LIMIT cycles.
//
// Optional build macro: MC_BNE_EN adds bne (opcode 000101) via state BNEEX.
// Without it, bne is treated as an illegal opcode.
//
// Parameters:
//   WAIT_LIMIT  max consecutive wait cycles in FETCH/MEMRD/MEMWR (0 = forever)
//   CNT_W       wait counter width (WAIT_LIMIT < 2**CNT_W)
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode, funct       instruction fields from the instruction register
//   zero                ALU zero flag (used in BEQEX/BNEEX)
//   mem_ready           memory completes the current access this cycle
//   iord .. pc_en       datapath mux selects and write enables
//   state_o             current state encoding (debug)
//   illegal             one-cycle pulse on undecodable opcode/funct
//   mem_timeout         one-cycle pulse when the wait limit expires
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int WAIT_LIMIT = 0,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [3:0] state_o,
  output logic       illegal,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam bit             TIMEOUT_EN = (WAIT_LIMIT > 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic wait_state;
  logic timeout_hit;

  // Raw FSM values for the enables that must be held low during reset.
  logic pc_en_fsm, ir_write_fsm, mem_write_fsm, reg_write_fsm;
  logic illegal_fsm, mem_timeout_fsm;

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign wait_state  = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                       (state_reg == S_MEMWR);
  // A ready in the expiry cycle completes the access instead of timing out.
  assign timeout_hit = TIMEOUT_EN && wait_state && !mem_ready &&
                       (wait_cnt_reg == LIMIT_M1);

  // Counter only runs while stalled in a memory state; any exit (completion
  // or timeout) starts the next wait from zero.
  always_comb begin
    wait_cnt_next = '0;
    if (wait_state && !mem_ready && !timeout_hit) begin
      wait_cnt_next = (wait_cnt_reg == CNT_MAX) ? wait_cnt_reg : wait_cnt_reg + CNT_ONE;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next      = state_reg;
    iord            = 1'b0;
    mem_read        = 1'b0;
    mem_write_fsm   = 1'b0;
    ir_write_fsm    = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    reg_write_fsm   = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_control     = 3'b000;
    pc_src          = 2'b00;
    pc_en_fsm       = 1'b0;
    illegal_fsm     = 1'b0;
    mem_timeout_fsm = timeout_hit;

    case (state_reg)
      S_FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        alu_control  = ALU_ADD;
        ir_write_fsm = mem_ready;
        pc_en_fsm    = mem_ready;
        if (mem_ready) state_next = S_DECODE;
        else           state_next = S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_next = S_BNEEX;
`endif
          default: begin
            illegal_fsm = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready)        state_next = S_MEMWB;
        else if (timeout_hit) state_next = S_FETCH;
        else                  state_next = S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_fsm = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_fsm = 1'b1;
        if (mem_ready)        state_next = S_FETCH;
        else if (timeout_hit) state_next = S_FETCH;
        else                  state_next = S_MEMWR;
      end
      S_RTYPEEX: begin
        alu_src_a  = 1'b1;
        state_next = S_RTYPEWB;
        case (funct)
          6'b100000: alu_control = ALU_ADD;
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default: begin
            illegal_fsm = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_RTYPEWB: begin
        reg_dst       = 1'b1;
        reg_write_fsm = 1'b1;
        state_next    = S_FETCH;
      end
      S_BEQEX: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en_fsm   = zero;
        state_next  = S_FETCH;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en_fsm   = ~zero;
        state_next  = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_fsm = 1'b1;
        state_next    = S_FETCH;
      end
      S_JEX: begin
        pc_src     = 2'b10;
        pc_en_fsm  = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Gate side-effecting strobes with rst_n so nothing is written while reset
  // is asserted, even in the cycle it falls.
  assign pc_en       = pc_en_fsm       & rst_n;
  assign ir_write    = ir_write_fsm    & rst_n;
  assign mem_write   = mem_write_fsm   & rst_n;
  assign reg_write   = reg_write_fsm   & rst_n;
  assign illegal     = illegal_fsm     & rst_n;
  assign mem_timeout = mem_timeout_fsm & rst_n;

  assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Two instances: dut (WAIT_LIMIT=0) for instruction flows and stalls, dut_to
// (WAIT_LIMIT=3) for timeout behaviour. Each task builds a per-cycle plan;
// driving a step pushes the expected output vector into a scoreboard queue,
// which is popped and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MWR = 4'd5, RX = 4'd6, RW = 4'd7, BQ = 4'd8, AX = 4'd9,
                         AW = 4'd10, JX = 4'd11, BN = 4'd12;
  localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000,
                         A_OR = 3'b001, A_SLT = 3'b111;
  localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011, O_R = 6'b000000,
                         O_BEQ = 6'b000100, O_BNE = 6'b000101, O_ADDI = 6'b001000,
                         O_J = 6'b000010, O_BAD = 6'b111111;
  localparam logic [5:0] F_SUB = 6'b100010;

  logic clk = 1'b0;
  logic rst_n, rst_to_n;
  logic [5:0] opcode, funct;
  logic zero, mem_ready, ready_to;

  logic iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, pc_en, illegal, mem_timeout;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  logic t_iord, t_mem_read, t_mem_write, t_ir_write, t_reg_dst, t_mem_to_reg, t_reg_write;
  logic t_alu_src_a, t_pc_en, t_illegal, t_mem_timeout;
  logic [1:0] t_alu_src_b, t_pc_src;
  logic [2:0] t_alu_control;
  logic [3:0] t_state_o;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_LIMIT(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .state_o(state_o),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  multicycle_control #(.WAIT_LIMIT(3), .CNT_W(8)) dut_to (
    .clk(clk), .rst_n(rst_to_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(ready_to), .iord(t_iord), .mem_read(t_mem_read), .mem_write(t_mem_write),
    .ir_write(t_ir_write), .reg_dst(t_reg_dst), .mem_to_reg(t_mem_to_reg),
    .reg_write(t_reg_write), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
    .alu_control(t_alu_control), .pc_src(t_pc_src), .pc_en(t_pc_en), .state_o(t_state_o),
    .illegal(t_illegal), .mem_timeout(t_mem_timeout)
  );

  logic [21:0] dvec, tvec;
  assign dvec = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, alu_control, pc_src, pc_en, state_o, illegal, mem_timeout};
  assign tvec = {t_iord, t_mem_read, t_mem_write, t_ir_write, t_reg_dst, t_mem_to_reg,
                 t_reg_write, t_alu_src_a, t_alu_src_b, t_alu_control, t_pc_src, t_pc_en,
                 t_state_o, t_illegal, t_mem_timeout};

  typedef struct {
    logic       rstn;
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] st;
    logic       pe;
    logic       iw;
    logic       ill;
    logic       to;
    logic [2:0] aluc;
  } step_t;

  logic [21:0] sb[$];
  int checks = 0;
  int passed = 0;

  // Expected output vector for one cycle, from the control table.
  function automatic logic [21:0] ev(input logic [3:0] st, input logic pe, input logic iw,
                                     input logic ill, input logic to, input logic [2:0] aluc);
    logic iord_e, mr, mw, rd, m2r, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] ac;
    iord_e = 0; mr = 0; mw = 0; rd = 0; m2r = 0; rw = 0; asa = 0;
    asb = 2'b00; pcs = 2'b00; ac = 3'b000;
    case (st)
      FE:      begin mr = 1; asb = 2'b01; ac = A_ADD; end
      DE:      begin asb = 2'b11; ac = A_ADD; end
      MA:      begin asa = 1; asb = 2'b10; ac = A_ADD; end
      MR:      begin iord_e = 1; mr = 1; end
      MWB:     begin m2r = 1; rw = 1; end
      MWR:     begin iord_e = 1; mw = 1; end
      RX:      begin asa = 1; ac = aluc; end
      RW:      begin rd = 1; rw = 1; end
      BQ, BN:  begin asa = 1; ac = A_SUB; pcs = 2'b01; end
      AX:      begin asa = 1; asb = 2'b10; ac = A_ADD; end
      AW:      begin rw = 1; end
      JX:      begin pcs = 2'b10; end
      default: ;
    endcase
    return {iord_e, mr, mw, iw, rd, m2r, rw, asa, asb, ac, pcs, pe, st, ill, to};
  endfunction

  function automatic step_t mk(input logic rstn, input logic rdy, input logic z,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic [3:0] st, input logic pe, input logic iw,
                               input logic ill, input logic to, input logic [2:0] aluc);
    step_t s;
    s.rstn = rstn; s.rdy = rdy; s.z = z; s.op = op; s.fn = fn; s.st = st;
    s.pe = pe; s.iw = iw; s.ill = ill; s.to = to; s.aluc = aluc;
    return s;
  endfunction

  // Apply one cycle of stimulus and record what the DUT must show for it.
  task automatic drive(input step_t s, input bit tinst);
    zero   = s.z;
    opcode = s.op;
    funct  = s.fn;
    if (tinst) begin
      rst_to_n = s.rstn;
      ready_to = s.rdy;
    end else begin
      rst_n     = s.rstn;
      mem_ready = s.rdy;
    end
    sb.push_back(ev(s.st, s.pe, s.iw, s.ill, s.to, s.aluc));
  endtask

  task automatic test_reset();
    step_t plan[$];
    logic [21:0] e;
    for (int k = 0; k < 3; k++) plan.push_back(mk(0, 1, 0, O_J, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_J, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_J, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_J, 0, JX, 1, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i], 0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (dvec !== e) $display("FAIL reset[%0d]: got %h expected %h", i, dvec, e);
      else passed++;
      @(posedge clk); #1;
    end
    $display("reset+jump: %0d cycles", plan.size());
  endtask

  task automatic test_lw();
    step_t plan[$];
    logic [21:0] e;
    plan.push_back(mk(1, 1, 0, O_LW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MA, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MWB, 0, 0, 0, 0, 0));
    // second lw with a one-cycle read stall
    plan.push_back(mk(1, 1, 0, O_LW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MA, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MWB, 0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i], 0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (dvec !== e) $display("FAIL lw[%0d]: got %h expected %h", i, dvec, e);
      else passed++;
      @(posedge clk); #1;
    end
    $display("lw: %0d cycles", plan.size());
  endtask

  task automatic test_rtype();
    step_t plan[$];
    logic [21:0] e;
    logic [5:0] fns [6];
    logic [2:0] acs [6];
    fns = '{6'b100000, F_SUB, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    acs = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT, 3'b000};
    for (int k = 0; k < 6; k++) begin
      plan.push_back(mk(1, 1, 0, O_R, fns[k], FE, 1, 1, 0, 0, 0));
      plan.push_back(mk(1, 1, 0, O_R, fns[k], DE, 0, 0, 0, 0, 0));
      if (k < 5) begin
        plan.push_back(mk(1, 1, 0, O_R, fns[k], RX, 0, 0, 0, 0, acs[k]));
        plan.push_back(mk(1, 1, 0, O_R, fns[k], RW, 0, 0, 0, 0, 0));
      end else begin
        plan.push_back(mk(1, 1, 0, O_R, fns[k], RX, 0, 0, 1, 0, acs[k]));
      end
    end
    foreach (plan[i]) begin
      drive(plan[i], 0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (dvec !== e) $display("FAIL rtype[%0d]: got %h expected %h", i, dvec, e);
      else passed++;
      @(posedge clk); #1;
    end
    $display("rtype: %0d cycles", plan.size());
  endtask

  task automatic test_branch();
    step_t plan[$];
    logic [21:0] e;
    for (int z = 1; z >= 0; z--) begin
      plan.push_back(mk(1, 1, z[0], O_BEQ, 0, FE, 1, 1, 0, 0, 0));
      plan.push_back(mk(1, 1, z[0], O_BEQ, 0, DE, 0, 0, 0, 0, 0));
      plan.push_back(mk(1, 1, z[0], O_BEQ, 0, BQ, z[0], 0, 0, 0, 0));
    end
    for (int z = 1; z >= 0; z--) begin
      plan.push_back(mk(1, 1, z[0], O_BNE, 0, FE, 1, 1, 0, 0, 0));
`ifdef MC_BNE_EN
      plan.push_back(mk(1, 1, z[0], O_BNE, 0, DE, 0, 0, 0, 0, 0));
      plan.push_back(mk(1, 1, z[0], O_BNE, 0, BN, ~z[0], 0, 0, 0, 0));
`else
      plan.push_back(mk(1, 1, z[0], O_BNE, 0, DE, 0, 0, 1, 0, 0));
`endif
    end
    foreach (plan[i]) begin
      drive(plan[i], 0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (dvec !== e) $display("FAIL branch[%0d]: got %h expected %h", i, dvec, e);
      else passed++;
      @(posedge clk); #1;
    end
    $display("beq/bne: %0d cycles", plan.size());
  endtask

  task automatic test_addi_illegal();
    step_t plan[$];
    logic [21:0] e;
    plan.push_back(mk(1, 1, 0, O_ADDI, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_ADDI, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_ADDI, 0, AX, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_ADDI, 0, AW, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_BAD, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_BAD, 0, DE, 0, 0, 1, 0, 0));
    plan.push_back(mk(1, 1, 0, 6'b000001, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, 6'b000001, 0, DE, 0, 0, 1, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i], 0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (dvec !== e) $display("FAIL addi_illegal[%0d]: got %h expected %h", i, dvec, e);
      else passed++;
      @(posedge clk); #1;
    end
    $display("addi/illegal: %0d cycles", plan.size());
  endtask

  task automatic test_sw_stall();
    step_t plan[$];
    logic [21:0] e;
    plan.push_back(mk(1, 0, 0, O_SW, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_SW, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, MA, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) plan.push_back(mk(1, 0, 0, O_SW, 0, MWR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, MWR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_SW, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, MA, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_SW, 0, MWR, 0, 0, 0, 0, 0));
    // reset mid-write: strobes drop in the same cycle
    plan.push_back(mk(0, 0, 0, O_SW, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, MA, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, MWR, 0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i], 0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (dvec !== e) $display("FAIL sw_stall[%0d]: got %h expected %h", i, dvec, e);
      else passed++;
      @(posedge clk); #1;
    end
    $display("sw stall/reset: %0d cycles", plan.size());
  endtask

  task automatic test_timeout();
    step_t plan[$];
    logic [21:0] e;
    rst_n = 1'b0;
    // fetch timeout, PC not written
    plan.push_back(mk(1, 0, 0, O_LW, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_LW, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_LW, 0, FE, 0, 0, 0, 1, 0));
    plan.push_back(mk(1, 0, 0, O_LW, 0, FE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MA, 0, 0, 0, 0, 0));
    // read timeout abandons lw, no MEMWB
    plan.push_back(mk(1, 0, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_LW, 0, MR, 0, 0, 0, 1, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MA, 0, 0, 0, 0, 0));
    // ready in the expiry cycle wins
    plan.push_back(mk(1, 0, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_LW, 0, MWB, 0, 0, 0, 0, 0));
    // write timeout
    plan.push_back(mk(1, 1, 0, O_SW, 0, FE, 1, 1, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, DE, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 1, 0, O_SW, 0, MA, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_SW, 0, MWR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_SW, 0, MWR, 0, 0, 0, 0, 0));
    plan.push_back(mk(1, 0, 0, O_SW, 0, MWR, 0, 0, 0, 1, 0));
    plan.push_back(mk(1, 0, 0, O_SW, 0, FE, 0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i], 1);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (tvec !== e) $display("FAIL timeout[%0d]: got %h expected %h", i, tvec, e);
      else passed++;
      @(posedge clk); #1;
    end
    $display("timeout: %0d cycles", plan.size());
  endtask

  initial begin
    rst_n = 1'b0; rst_to_n = 1'b0;
    mem_ready = 1'b1; ready_to = 1'b1;
    zero = 1'b0; opcode = O_J; funct = 6'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_addi_illegal();
    test_sw_stall();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
